sobel_edge_filter: RTL and testbench

//  Downstream stage of the grayscale image path: takes 4-bit gray pixels plus DE/sync from the
//  VGA pipeline and outputs either delayed gray (bypass) or a thresholded 3x3 Sobel edge map.
//  Two internal line buffers give a streaming 3x3 window. Sync/DE are delayed to match pixel latency.

---
 rtl/sobel_edge_filter.sv | 197 +++++++++++++++++++
 tb/tb_sobel_edge_filter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge detector / gray bypass for a 4-bit pixel stream.
// Two line buffers feed a 3x3 window; DE and syncs ride alongside so every output lags by 3 pix_en ticks.
module sobel_edge_filter #(
    parameter int H_ACTIVE  = 640,
    parameter int THRESHOLD = 24,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       i_de,
    input  logic       i_h_sync,
    input  logic       i_v_sync,
    input  logic [3:0] i_gray,
    input  logic       i_mode,
    output logic       o_de,
    output logic       o_h_sync,
    output logic       o_v_sync,
    output logic [3:0] o_r,
    output logic [3:0] o_g,
    output logic [3:0] o_b
);
    localparam int COL_W = (H_ACTIVE > 2) ? $clog2(H_ACTIVE) : 2;
    localparam int ROW_W = 11;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = '1;
    localparam logic SYNC_IDLE = ~SYNC_POL;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic pass;
        logic edge_ok;
        logic mode;
    } flags_t;

    localparam flags_t FLAGS_RST = '{1'b0, SYNC_IDLE, SYNC_IDLE, 1'b0, 1'b0, 1'b0};

    state_t state_reg, state_next;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic de_prev_reg, vs_prev_reg, mode_reg;
    logic vs_active, pass_en, edge_en;

    assign vs_active = (i_v_sync == SYNC_POL);

    // Position counters and frame-level mode latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_reg     <= '0;
            row_reg     <= '0;
            de_prev_reg <= 1'b0;
            vs_prev_reg <= 1'b0;
            mode_reg    <= 1'b0;
        end else if (pix_en) begin
            de_prev_reg <= i_de;
            vs_prev_reg <= vs_active;
            if (!i_de)
                col_reg <= '0;
            else if (col_reg != COL_MAX)
                col_reg <= col_reg + 1'b1;
            if (vs_active)
                row_reg <= '0;
            else if (de_prev_reg && !i_de && row_reg != ROW_MAX)
                row_reg <= row_reg + 1'b1;
            if (vs_active && !vs_prev_reg)
                mode_reg <= i_mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else if (pix_en)
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (vs_active) state_next = FILL;
            FILL:    if (row_reg == ROW_W'(2) && i_de) state_next = RUN;
            RUN:     if (vs_active) state_next = FILL;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pass_en = (state_reg != IDLE);
        edge_en = (state_reg == RUN) && (col_reg >= COL_W'(2)) && (row_reg >= ROW_W'(2));
    end

    // Line buffers: LB1 takes LB0's previous content at the same column (read-before-write)
    logic [3:0] lb0_mem [H_ACTIVE];
    logic [3:0] lb1_mem [H_ACTIVE];
    logic [3:0] lb0_q_reg, lb1_q_reg;

    always_ff @(posedge clk) begin
        if (pix_en) begin
            lb0_q_reg <= lb0_mem[col_reg];
            lb1_q_reg <= lb1_mem[col_reg];
            if (i_de) begin
                lb0_mem[col_reg] <= i_gray;
                lb1_mem[col_reg] <= lb0_mem[col_reg];
            end
        end
    end

    logic [3:0] gray1_reg;
    flags_t     in_flags, s1_reg, s2_reg;

    always_comb in_flags = '{i_de, i_h_sync, i_v_sync, pass_en, edge_en, mode_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray1_reg <= '0;
            s1_reg    <= FLAGS_RST;
            s2_reg    <= FLAGS_RST;
        end else if (pix_en) begin
            gray1_reg <= i_gray;
            s1_reg    <= in_flags;
            s2_reg    <= s1_reg;
        end
    end

    // Window row 0 = two lines up (LB1), row 2 = current line; column 2 is the newest pixel
    logic [3:0] col_vec [3];
    logic [3:0] p [3][3];

    assign col_vec[0] = lb1_q_reg;
    assign col_vec[1] = lb0_q_reg;
    assign col_vec[2] = gray1_reg;

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [3:0] tap_reg [3];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                tap_reg[0] <= '0;
                tap_reg[1] <= '0;
                tap_reg[2] <= '0;
            end else if (pix_en) begin
                tap_reg[0] <= tap_reg[1];
                tap_reg[1] <= tap_reg[2];
                tap_reg[2] <= col_vec[gi];
            end
        end
        assign p[gi][0] = tap_reg[0];
        assign p[gi][1] = tap_reg[1];
        assign p[gi][2] = tap_reg[2];
    end

    logic [6:0] sum_r, sum_l, sum_b, sum_t, dx, dy, abs_x, abs_y, mag;

    assign sum_r = 7'(p[0][2]) + 7'({p[1][2], 1'b0}) + 7'(p[2][2]);
    assign sum_l = 7'(p[0][0]) + 7'({p[1][0], 1'b0}) + 7'(p[2][0]);
    assign sum_b = 7'(p[2][0]) + 7'({p[2][1], 1'b0}) + 7'(p[2][2]);
    assign sum_t = 7'(p[0][0]) + 7'({p[0][1], 1'b0}) + 7'(p[0][2]);
    assign dx    = sum_r - sum_l;
    assign dy    = sum_b - sum_t;
    assign abs_x = dx[6] ? (7'd0 - dx) : dx;
    assign abs_y = dy[6] ? (7'd0 - dy) : dy;
    assign mag   = abs_x + abs_y;

    logic [3:0] pix_sel, pix_reg;

    always_comb begin
        pix_sel = 4'h0;
        if (s2_reg.de && s2_reg.pass) begin
            if (!s2_reg.mode)
                pix_sel = p[2][2];
            else if (s2_reg.edge_ok && mag > 7'(THRESHOLD))
                pix_sel = 4'hF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_de     <= 1'b0;
            o_h_sync <= SYNC_IDLE;
            o_v_sync <= SYNC_IDLE;
            pix_reg  <= 4'h0;
        end else if (pix_en) begin
            o_de     <= s2_reg.de;
            o_h_sync <= s2_reg.hs;
            o_v_sync <= s2_reg.vs;
            pix_reg  <= pix_sel;
        end
    end

    assign o_r = pix_reg;
    assign o_g = pix_reg;
    assign o_b = pix_reg;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Randomized bench for sobel_edge_filter: frames are streamed under several pix_en patterns and every
// cycle's outputs are checked against an image-level reference model held in the bench.
module tb_sobel_edge_filter;
    localparam int H    = 24;
    localparam int HB   = 6;
    localparam int R    = 6;
    localparam int MAXR = 16;
    localparam int THR  = 24;
    localparam int IDLE_S = 0, FILL_S = 1, RUN_S = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;
    logic       de = 1'b0, hs = 1'b1, vs = 1'b1, mode = 1'b0;
    logic [3:0] gray = 4'h0;
    logic       o_de, o_hs, o_vs;
    logic [3:0] o_r, o_g, o_b;

    always #5 clk = ~clk;

    sobel_edge_filter #(.H_ACTIVE(H), .THRESHOLD(THR), .SYNC_POL(1'b0)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .i_de(de), .i_h_sync(hs), .i_v_sync(vs), .i_gray(gray), .i_mode(mode),
        .o_de(o_de), .o_h_sync(o_hs), .o_v_sync(o_vs), .o_r(o_r), .o_g(o_g), .o_b(o_b)
    );

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [3:0] pix;
    } out_t;

    localparam out_t RST_OUT = '{1'b0, 1'b1, 1'b1, 4'h0};

    out_t exp_q[$];
    out_t cur_exp = RST_OUT;
    int   n_cmp = 0, n_bad = 0, edge_cnt = 0, frame_no = 0, en_mode = 0;
    logic mode_in = 1'b0;

    // Reference model: what the spec says the stream position, frame state and image are
    int   m_col, m_row, m_state;
    logic m_mode, m_de_prev, m_vs_prev;
    int   img [MAXR][H];
    int   win [3][3];

    function automatic int sobel_win();
        int gx, gy;
        gx = (win[0][2] + 2 * win[1][2] + win[2][2]) - (win[0][0] + 2 * win[1][0] + win[2][0]);
        gy = (win[2][0] + 2 * win[2][1] + win[2][2]) - (win[0][0] + 2 * win[0][1] + win[0][2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy > THR) ? 15 : 0;
    endfunction

    function automatic void model_reset();
        m_col = 0; m_row = 0; m_state = IDLE_S;
        m_mode = 1'b0; m_de_prev = 1'b0; m_vs_prev = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST_OUT);
        exp_q.push_back(RST_OUT);
        cur_exp = RST_OUT;
    endfunction

    function automatic out_t model_tick(logic d, logic h, logic v, logic [3:0] g, logic md);
        out_t o;
        logic v_act;
        v_act = (v == 1'b0);
        o.de = d; o.hs = h; o.vs = v; o.pix = 4'h0;
        if (d && m_row < MAXR) img[m_row][m_col] = int'(g);
        if (d && m_state != IDLE_S) begin
            if (!m_mode)
                o.pix = g;
            else if (m_state == RUN_S && m_col >= 2 && m_row >= 2 && m_row < MAXR) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        win[i][j] = img[m_row - 2 + i][m_col - 2 + j];
                o.pix = 4'(sobel_win());
            end
        end
        case (m_state)
            IDLE_S:  if (v_act) m_state = FILL_S;
            FILL_S:  if (m_row == 2 && d) m_state = RUN_S;
            default: if (v_act) m_state = FILL_S;
        endcase
        if (!d) m_col = 0;
        else if (m_col < H - 1) m_col++;
        if (v_act) m_row = 0;
        else if (m_de_prev && !d) m_row++;
        if (v_act && !m_vs_prev) m_mode = md;
        m_de_prev = d;
        m_vs_prev = v_act;
        return o;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_out(input logic en);
        out_t got;
        got = '{o_de, o_hs, o_vs, o_r};
        n_cmp++;
        if (got !== cur_exp || o_g !== o_r || o_b !== o_r) begin
            n_bad++;
            $display("FAIL cycle t=%0t got de=%b hs=%b vs=%b rgb=%h/%h/%h want de=%b hs=%b vs=%b pix=%h",
                     $time, o_de, o_hs, o_vs, o_r, o_g, o_b, cur_exp.de, cur_exp.hs, cur_exp.vs, cur_exp.pix);
        end
        if (en && o_de === 1'b1 && o_r === 4'hF) edge_cnt++;
    endtask

    task automatic do_cycle(input logic en, input logic d, input logic h, input logic v, input logic [3:0] g);
        pix_en = en;
        if (en) begin
            de = d; hs = h; vs = v; gray = g; mode = mode_in;
            exp_q.push_back(model_tick(d, h, v, g, mode_in));
        end else begin
            de = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
            gray = 4'($urandom); mode = 1'($urandom);
        end
        @(posedge clk);
        #1;
        if (en) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL model_queue empty at t=%0t", $time);
            end else
                cur_exp = exp_q.pop_front();
        end
        check_out(en);
        @(negedge clk);
    endtask

    task automatic tick(input logic d, input logic h, input logic v, input logic [3:0] g);
        int idle;
        idle = (en_mode == 1) ? 3 : ((en_mode == 2) ? int'($urandom_range(0, 2)) : 0);
        repeat (idle) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        do_cycle(1'b1, d, h, v, g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        cur_exp = RST_OUT;
        check_out(1'b0);
        @(posedge clk);
        #1;
        check_out(1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [3:0] pix_val(int pat, int c, int r);
        case (pat)
            0:       return 4'h8;
            1:       return (c < 10) ? 4'h0 : 4'hF;
            2:       return (r < 3) ? 4'h0 : 4'hF;
            3:       return 4'(c);
            5:       return (c >= H - 3) ? 4'h5 : 4'($urandom);
            default: return 4'($urandom);
        endcase
    endfunction

    task automatic run_frame(input int pat, input bit ovr, input int tog_row, input int rst_row);
        int len;
        edge_cnt = 0;
        for (int l = 0; l < 2; l++)
            for (int k = 0; k < H + HB; k++)
                tick(1'b0, !(k >= 1 && k <= 2), 1'b0, 4'($urandom));
        for (int r = 0; r < R; r++) begin
            if (r == tog_row) mode_in = ~mode_in;
            len = (ovr && (r % 2 == 1)) ? H + 3 : H;
            for (int c = 0; c < len; c++) begin
                if (r == rst_row && c == H / 2) do_reset();
                tick(1'b1, 1'b1, 1'b1, pix_val(pat, c, r));
            end
            for (int k = 0; k < HB; k++)
                tick(1'b0, !(k >= 1 && k <= 2), 1'b1, 4'($urandom));
        end
        frame_no++;
        $display("frame %0d pattern %0d en_mode %0d mode_in %0b edges %0d", frame_no, pat, en_mode, mode_in, edge_cnt);
    endtask

    task automatic pin(input string name, input logic [11:0] t, input logic [11:0] m,
                       input logic [11:0] b, input int want);
        logic [11:0] rows [3];
        rows[0] = t; rows[1] = m; rows[2] = b;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                win[i][j] = int'(rows[i][4*j +: 4]);
        chk(name, sobel_win(), want);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Hand-computed windows (nibble 0 = left column) pin the model's Sobel arithmetic
        pin("pin_vstep",   12'hF00, 12'hF00, 12'hF00, 15);
        pin("pin_uniform", 12'h888, 12'h888, 12'h888, 0);
        pin("pin_mag24",   12'h600, 12'h600, 12'h600, 0);
        pin("pin_mag26",   12'h700, 12'h600, 12'h600, 15);
        pin("pin_hstep",   12'h000, 12'h000, 12'hFFF, 15);

        en_mode = 0;
        mode_in = 1'b1;
        run_frame(4, 1'b0, -1, -1);
        run_frame(0, 1'b0, -1, -1);
        chk("uniform_edges", edge_cnt, 0);
        run_frame(1, 1'b0, -1, -1);
        chk("vstep_edges", edge_cnt, 2 * (R - 2));
        run_frame(2, 1'b0, -1, -1);
        chk("hstep_edges", edge_cnt, 2 * (H - 2));
        mode_in = 1'b0;
        run_frame(3, 1'b0, 3, -1);
        chk("ramp_bypass_f", edge_cnt, R);
        run_frame(4, 1'b0, -1, -1);

        en_mode = 1;
        run_frame(4, 1'b0, -1, -1);
        run_frame(1, 1'b0, -1, -1);
        chk("vstep_edges_slow", edge_cnt, 2 * (R - 2));
        mode_in = 1'b0;
        run_frame(4, 1'b0, -1, -1);
        mode_in = 1'b1;

        en_mode = 2;
        run_frame(4, 1'b0, -1, -1);
        run_frame(5, 1'b1, -1, -1);
        run_frame(4, 1'b0, -1, 2);
        run_frame(4, 1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
